// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rca_pkg
// Purpose  : Shared types, constants and golden model for the adder self-test.
// Revision : 1.0
// ============================================================================
package rca_pkg;

    localparam int          c_width_default = 4;
    localparam int          c_max_width     = 7;
    localparam logic [15:0] c_lfsr_taps     = 16'hB400;
    localparam logic [15:0] c_seed_default  = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_t;

    typedef logic [c_max_width-1:0] operand_t;
    typedef logic [c_max_width:0]   result_t;

    // Operands are zero-extended to the widest legal size so one function serves every WIDTH.
    function automatic result_t golden_add(input operand_t a, input operand_t b, input logic c_in);
        return result_t'(a) + result_t'(b) + result_t'(c_in);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Purpose  : 16-bit right-shifting Galois LFSR with seed load and step enable.
// Revision : 1.0
// ============================================================================
module lfsr16
    import rca_pkg::*;
#(
    parameter logic [15:0] TAPS = c_lfsr_taps
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] r_state;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_state <= seed;
        end else if (step) begin
            r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? TAPS : 16'h0000);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/rca_self_test.sv
`default_nettype none
// ============================================================================
// Module   : rca_self_test
// Purpose  : BIST controller driving and checking a ripple-carry adder.
// Revision : 1.0
// ============================================================================
module rca_self_test
    import rca_pkg::*;
#(
    parameter int          WIDTH       = c_width_default,
    parameter int          NUM_VECTORS = 16,
    parameter int          SETTLE      = 1,
    parameter logic [15:0] SEED        = c_seed_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic             dut_c_in,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_c_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [15:0]      vec_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_c_in,
    output logic             fail_valid
);

    state_t           r_state;
    logic [3:0]       r_settle;
    logic [WIDTH-1:0] r_a, r_b, r_fail_a, r_fail_b;
    logic             r_c_in, r_fail_c_in, r_fail_valid;
    logic             r_busy, r_done, r_pass;
    logic [7:0]       r_err;
    logic [15:0]      r_vec;

    logic [15:0]      w_lfsr;
    logic             w_lfsr_load, w_lfsr_step;
    logic             w_mismatch, w_last;
    logic [7:0]       w_err_next;
    logic [15:0]      w_vec_next;

    assign w_lfsr_load = (r_state == IDLE) && start;
    assign w_vec_next  = r_vec + 16'd1;
    assign w_last      = (w_vec_next == 16'(NUM_VECTORS));
    assign w_lfsr_step = (r_state == SAMPLE) && !w_last;
    assign w_mismatch  = result_t'({dut_c_out, dut_sum}) !=
                         golden_add(operand_t'(r_a), operand_t'(r_b), r_c_in);
    assign w_err_next  = (w_mismatch && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;

    lfsr16 #(
        .TAPS  (c_lfsr_taps)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (w_lfsr_load),
        .seed  (SEED),
        .step  (w_lfsr_step),
        .state (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_settle     <= 4'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_c_in       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= 8'd0;
            r_vec        <= 16'd0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_c_in  <= 1'b0;
            r_fail_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= DRIVE;
                        r_settle     <= 4'd0;
                        r_busy       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_err        <= 8'd0;
                        r_vec        <= 16'd0;
                        r_a          <= '0;
                        r_b          <= '0;
                        r_c_in       <= 1'b0;
                        r_fail_a     <= '0;
                        r_fail_b     <= '0;
                        r_fail_c_in  <= 1'b0;
                        r_fail_valid <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (r_settle == 4'(SETTLE - 1)) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                SAMPLE: begin
                    r_err <= w_err_next;
                    r_vec <= w_vec_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_a     <= r_a;
                        r_fail_b     <= r_b;
                        r_fail_c_in  <= r_c_in;
                        r_fail_valid <= 1'b1;
                    end
                    if (w_last) begin
                        r_state <= FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 8'd0);
                    end else begin
                        // Next vector comes from the LFSR state before it advances.
                        r_state  <= DRIVE;
                        r_settle <= 4'd0;
                        r_a      <= WIDTH'(w_lfsr);
                        r_b      <= WIDTH'(w_lfsr >> WIDTH);
                        r_c_in   <= w_lfsr[15];
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dut_a      = r_a;
    assign dut_b      = r_b;
    assign dut_c_in   = r_c_in;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign vec_count  = r_vec;
    assign fail_a     = r_fail_a;
    assign fail_b     = r_fail_b;
    assign fail_c_in  = r_fail_c_in;
    assign fail_valid = r_fail_valid;

endmodule
`default_nettype wire

// File: tb/tb_rca_self_test.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_self_test
// Purpose  : Self-checking bench for rca_self_test with a behavioural adder.
// Revision : 1.0
// ============================================================================
module tb_rca_self_test;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic inv_cout = 1'b0;

    always #5 clk = ~clk;

    logic [3:0]  dut_a, dut_b, dut_sum, fail_a, fail_b;
    logic        dut_c_in, dut_c_out, busy, done, pass, fail_c_in, fail_valid;
    logic [7:0]  err_count;
    logic [15:0] vec_count;
    logic [4:0]  add1;

    assign add1      = 5'(dut_a) + 5'(dut_b) + 5'(dut_c_in);
    assign dut_sum   = add1[3:0];
    assign dut_c_out = add1[4] ^ inv_cout;

    rca_self_test dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dut_a      (dut_a),
        .dut_b      (dut_b),
        .dut_c_in   (dut_c_in),
        .dut_sum    (dut_sum),
        .dut_c_out  (dut_c_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .vec_count  (vec_count),
        .fail_a     (fail_a),
        .fail_b     (fail_b),
        .fail_c_in  (fail_c_in),
        .fail_valid (fail_valid)
    );

    // Second instance: long run against an adder whose carry-out is always inverted.
    logic [3:0]  a2, b2, sum2, fa2, fb2;
    logic        cin2, cout2, busy2, done2, pass2, fcin2, fvalid2;
    logic [7:0]  err2;
    logic [15:0] vec2;
    logic [4:0]  add2;

    assign add2  = 5'(a2) + 5'(b2) + 5'(cin2);
    assign sum2  = add2[3:0];
    assign cout2 = ~add2[4];

    rca_self_test #(.NUM_VECTORS(300)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .dut_a      (a2),
        .dut_b      (b2),
        .dut_c_in   (cin2),
        .dut_sum    (sum2),
        .dut_c_out  (cout2),
        .busy       (busy2),
        .done       (done2),
        .pass       (pass2),
        .err_count  (err2),
        .vec_count  (vec2),
        .fail_a     (fa2),
        .fail_b     (fb2),
        .fail_c_in  (fcin2),
        .fail_valid (fvalid2)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
    } vec_t;

    vec_t tbl[16];
    vec_t sb[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic start_run(input bit second);
        @(negedge clk);
        if (second) start2 = 1'b1;
        else        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Called #1 after the start edge; walks the full 16-vector run cycle by cycle.
    task automatic run_check(input bit bad, input int restart_at);
        vec_t e;
        int   k;
        for (int i = 0; i < 16; i++) sb.push_back(tbl[i]);
        for (int j = 0; j <= 33; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            if (j == restart_at)          start = 1'b1;
            else if (j == restart_at + 1) start = 1'b0;
            chk("busy", int'(busy), int'(j < 32));
            chk("done", int'(done), int'(j == 32));
            if (j < 32 && (j % 2) == 1) begin
                k = (j - 1) / 2;
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("vec_a", int'(dut_a), int'(e.a));
                    chk("vec_b", int'(dut_b), int'(e.b));
                    chk("vec_c_in", int'(dut_c_in), int'(e.c));
                    chk("vec_count_mid", int'(vec_count), k);
                end
            end
            if (j == 3) begin
                chk("vec1_a", int'(dut_a), 1);
                chk("vec1_b", int'(dut_b), 14);
                chk("vec1_c_in", int'(dut_c_in), 1);
            end
        end
        chk("pass", int'(pass), bad ? 0 : 1);
        chk("err_count", int'(err_count), bad ? 16 : 0);
        chk("vec_count", int'(vec_count), 16);
        chk("fail_valid", int'(fail_valid), bad ? 1 : 0);
        chk("fail_a", int'(fail_a), 0);
        chk("fail_b", int'(fail_b), 0);
        chk("fail_c_in", int'(fail_c_in), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dut_a"}, int'(dut_a), 0);
        chk({tag, "_dut_b"}, int'(dut_b), 0);
        chk({tag, "_dut_c_in"}, int'(dut_c_in), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_vec_count"}, int'(vec_count), 0);
        chk({tag, "_fail_a"}, int'(fail_a), 0);
        chk({tag, "_fail_b"}, int'(fail_b), 0);
        chk({tag, "_fail_c_in"}, int'(fail_c_in), 0);
        chk({tag, "_fail_valid"}, int'(fail_valid), 0);
    endtask

    initial begin
        logic [15:0] s;
        int          seen;
        int          cnt;

        s = 16'hACE1;
        tbl[0] = '{a: 4'h0, b: 4'h0, c: 1'b0};
        for (int i = 1; i < 16; i++) begin
            tbl[i] = '{a: s[3:0], b: s[7:4], c: s[15]};
            s = lfsr_next(s);
        end

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_busy2", int'(busy2), 0);
        @(negedge clk);
        rst = 1'b0;

        // Clean run with a correct adder.
        start_run(1'b0);
        run_check(1'b0, -1);

        // Every vector fails when carry-out is inverted.
        inv_cout = 1'b1;
        start_run(1'b0);
        run_check(1'b1, -1);
        inv_cout = 1'b0;

        // Reset five cycles into a run.
        start_run(1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all_zero("midrst");
        seen = 0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        chk("no_activity_after_rst", seen, 0);

        start_run(1'b0);
        run_check(1'b0, -1);

        // Extra start pulse three cycles into the run is ignored.
        start_run(1'b0);
        run_check(1'b0, 3);

        // Long run: error count saturates.
        start_run(1'b1);
        cnt = 0;
        while (!done2 && cnt < 1000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("long_done_cycle", cnt, 600);
        chk("long_err_count", int'(err2), 255);
        chk("long_vec_count", int'(vec2), 300);
        chk("long_pass", int'(pass2), 0);
        chk("long_fail_valid", int'(fvalid2), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rca_self_test.md
Name: rca_self_test

Overview:
- Built-in self-test controller for the ripple-carry adder.
- Drives operand vectors (a, b, c_in) into an adder under test, samples sum/c_out, and checks them against an internal golden a+b+c_in.
- Reports pass/fail, an error count, and the first failing vector.
- Sits beside the adder in hardware; it is the synthesizable consumer/checker end of the adder's a/b/c_in -> sum/c_out interface.

Parameters:
- WIDTH, 4, operand width; legal range 1..7, so that 2*WIDTH+1 <= 16.
- NUM_VECTORS, 16, vectors per run including the all-zero vector 0; legal range 1..65535.
- SETTLE, 1, cycles the vector is held before sampling; legal range 1..15.
- SEED, 16'hACE1, LFSR seed; must be nonzero.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level-sampled run request.
- dut_a  output  WIDTH  operand a to the adder.
- dut_b  output  WIDTH  operand b to the adder.
- dut_c_in  output  1  carry-in to the adder.
- dut_sum  input  WIDTH  adder sum.
- dut_c_out  input  1  adder carry-out.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  last run had zero errors; valid while done/IDLE after a run.
- err_count  output  8  mismatches, saturating at 255.
- vec_count  output  16  vectors checked so far.
- fail_a  output  WIDTH  a of the first failing vector.
- fail_b  output  WIDTH  b of the first failing vector.
- fail_c_in  output  1  c_in of the first failing vector.
- fail_valid  output  1  fail_* fields hold a captured failure.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, and wins over every other input.
- Reset values: all outputs 0, including pass; state IDLE; LFSR loaded with SEED.
- FSM states: IDLE, DRIVE, SAMPLE, FIN.
- IDLE: when start=1 at an edge, go to DRIVE. Clear err_count, vec_count and fail_*, clear pass, reload the LFSR with SEED, and load vector 0 = {a=0, b=0, c_in=0}.
- Driven outputs: dut_a/dut_b/dut_c_in are registered. They change only on entry to DRIVE and are held stable otherwise.
- DRIVE: a settle counter counts SETTLE edges, then the FSM goes to SAMPLE. busy=1 in DRIVE and SAMPLE.
- SAMPLE (exactly one cycle):
  - Compare {dut_c_out, dut_sum} against the golden value, computed at WIDTH+1 bits as a+b+c_in with no truncation before the compare.
  - On mismatch: err_count increments, saturating at 255. If fail_valid=0, capture the vector into fail_* and set fail_valid=1.
  - vec_count increments.
  - If vec_count reaches NUM_VECTORS, go to FIN.
  - Otherwise load the next vector from the LFSR, advance the LFSR, and go to DRIVE.
- Vector k>=1 uses the LFSR state s(k-1), where s(0)=SEED:
  - a = s[WIDTH-1:0]
  - b = s[2*WIDTH-1:WIDTH]
  - c_in = s[15]
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400, never all-zero.
- FIN (one cycle): done=1, pass=(err_count==0), busy=0, then go to IDLE. pass, err_count, vec_count and fail_* hold until the next accepted start or rst.
- Timing: start accepted at edge k gives vector 0 on the outputs after edge k. done is high in the cycle after edge k + NUM_VECTORS*(SETTLE+1). With the defaults, done is high 32 cycles after the start edge.
- start while busy or in FIN: ignored. Holding start=1 continuously starts back-to-back runs, with one IDLE cycle between them.
- rst mid-run: immediate return to reset values. No done pulse is produced.
- The comparison happens only in SAMPLE. dut_sum/dut_c_out are don't-care in all other states.

Decomposition:
- Shared package rca_pkg:
  - WIDTH default
  - LFSR tap mask 16'hB400
  - default SEED
  - FSM state encoding (IDLE=0, DRIVE=1, SAMPLE=2, FIN=3)
  - function golden_add(a, b, c_in) returning WIDTH+1 bits
- One sub-module, lfsr16: inputs clk, rst, load, seed, step; output state. Reusable for other stimulus blocks.

Test Plan:
- Correct rca connected, defaults, start pulse -> busy for 32 cycles, then done=1 for one cycle; pass=1, err_count=0, vec_count=16, fail_valid=0.
- Defaults: vector 1 observed on the outputs must be a=0x1, b=0xE, c_in=1. A correct adder returns sum=0x0, c_out=1, which must not be counted as an error.
- Faulty adder model with inverted c_out -> every vector fails: err_count=16, pass=0, fail_valid=1, fail_a=0, fail_b=0, fail_c_in=0 (vector 0).
- NUM_VECTORS=300 with the inverted-c_out model -> err_count saturates at 255, vec_count=300, pass=0.
- Assert rst 5 cycles into a run -> all outputs 0 on the next cycle, no done pulse. A later start then produces a full clean 16-vector run.
- Pulse start again 3 cycles into a run -> ignored; done arrives at the original cycle and vec_count=16.
